// File: rtl/enable_sequencer_pkg.sv
// Shared types and default widths for the enable sequencer.
package enable_sequencer_pkg;

  localparam int unsigned DEF_PERIOD_W = 8;
  localparam int unsigned DEF_BURST_W  = 8;

  // Burst controller states; completion is a flag, not a state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/enable_prescaler.sv
// Pulse-spacing prescaler: counts up from zero and flags terminal count when the
// count equals the latched period. No wrap logic: the owner clears it on terminal
// count, so the count never passes period_i.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   clr_i         - clear count to zero (has priority over inc_i)
//   inc_i         - advance count by one
//   period_i      - terminal value (full-width equality compare)
//   tc_c          - combinational terminal-count flag
module enable_prescaler #(
  parameter int unsigned PERIOD_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tc_c
);

  logic [PERIOD_W-1:0] cnt_q;

  // Count register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + PERIOD_W'(1);
    end
  end

  assign tc_c = (cnt_q == period_i);

endmodule

// File: rtl/enable_sequencer.sv
// Generates the enable input of the downstream 2-bit counter as programmable pulse
// trains: burst_len single-cycle pulses spaced period+1 clocks apart (or continuous
// when burst_len is 0), followed by a one-cycle done flag. Abort ends a burst at once.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   start         - request a burst; honoured only while idle and not aborting
//   abort         - stop the running burst; wins over start
//   period        - pulse spacing minus one, latched at start
//   burst_len     - pulses per burst, latched at start (0 = continuous)
//   enable        - registered enable pulse to the counter
//   busy          - high while a burst runs
//   done          - one-cycle pulse after the last pulse of a finite burst
//   pulse_count   - pulses emitted in current/last burst, saturating
module enable_sequencer
  import enable_sequencer_pkg::*;
#(
  parameter int unsigned PERIOD_W = DEF_PERIOD_W,
  parameter int unsigned BURST_W  = DEF_BURST_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] period,
  input  logic [BURST_W-1:0]  burst_len,
  output logic                enable,
  output logic                busy,
  output logic                done,
  output logic [BURST_W-1:0]  pulse_count
);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [BURST_W-1:0]  count_q, count_d;
  logic                enable_q, enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                presc_clr_c;
  logic                presc_inc_c;
  logic                presc_tc_c;

  enable_prescaler #(
    .PERIOD_W (PERIOD_W)
  ) u_presc (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (presc_clr_c),
    .inc_i    (presc_inc_c),
    .period_i (period_q),
    .tc_c     (presc_tc_c)
  );

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    burst_d     = burst_q;
    count_d     = count_q;
    enable_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    presc_clr_c = 1'b0;
    presc_inc_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        presc_clr_c = 1'b1;
        busy_d      = 1'b0;
        if (start && !abort) begin
          period_d = period;
          burst_d  = burst_len;
          state_d  = ST_RUN;
          busy_d   = 1'b1;
          enable_d = 1'b1;
          count_d  = BURST_W'(1);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          presc_clr_c = 1'b1;
        end else if ((burst_q != '0) && (count_q == burst_q) && enable_q) begin
          // Last pulse of a finite burst is currently on the output
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          presc_clr_c = 1'b1;
        end else if (presc_tc_c) begin
          presc_clr_c = 1'b1;
          enable_d    = 1'b1;
          // Saturation only matters for continuous bursts
          if (count_q != '1) begin
            count_d = count_q + BURST_W'(1);
          end
        end else begin
          presc_inc_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      burst_q  <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      burst_q  <= burst_d;
      count_q  <= count_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign enable      = enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulse_count = count_q;

endmodule

// File: tb/tb_enable_sequencer.sv
// Bench for enable_sequencer: expected per-cycle outputs are derived from the burst
// parameters, queued when stimulus is driven and compared one cycle later. A bench-side
// 2-bit counter plays the downstream consumer of enable.
module tb_enable_sequencer;

  typedef struct {
    logic en;
    logic bsy;
    logic dn;
    int   cnt;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] period;
  logic [7:0] burst_len;
  logic       enable;
  logic       busy;
  logic       done;
  logic [7:0] pulse_count;
  logic [1:0] cnt2;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;
  int   last_cnt;
  int   exp_total;

  enable_sequencer #(
    .PERIOD_W (8),
    .BURST_W  (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .period      (period),
    .burst_len   (burst_len),
    .enable      (enable),
    .busy        (busy),
    .done        (done),
    .pulse_count (pulse_count)
  );

  // Downstream 2-bit counter driven by enable
  always_ff @(posedge clock) begin
    if (reset) cnt2 <= 2'd0;
    else if (enable) cnt2 <= cnt2 + 2'd1;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Expected outputs in cycle k after a start edge (k=1 is the first cycle after it).
  // ak: cycle during which abort is held (0 = none).
  function automatic exp_t exp_at(input int k, input int p, input int b, input int ak);
    exp_t e;
    int   kl;
    int   np;
    e.en  = 1'b0;
    e.bsy = 1'b0;
    e.dn  = 1'b0;
    kl    = (b != 0) ? 1 + (b - 1) * (p + 1) : 0;
    if (ak != 0 && k > ak) begin
      np = (ak - 1) / (p + 1) + 1;
    end else if (b != 0 && k > kl) begin
      e.dn = (k == kl + 1);
      np   = b;
    end else begin
      e.en  = ((k - 1) % (p + 1) == 0);
      e.bsy = 1'b1;
      np    = (k - 1) / (p + 1) + 1;
    end
    e.cnt = (np > 255) ? 255 : np;
    return e;
  endfunction

  function automatic exp_t idle_exp(input int cnt);
    exp_t e;
    e.en  = 1'b0;
    e.bsy = 1'b0;
    e.dn  = 1'b0;
    e.cnt = cnt;
    return e;
  endfunction

  task automatic push_exp(input exp_t e);
    sb.push_back(e);
    exp_total += int'(e.en);
    last_cnt  = e.cnt;
  endtask

  task automatic compare_cycle();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("enable", 32'(enable), 32'(e.en));
      chk("busy", 32'(busy), 32'(e.bsy));
      chk("done", 32'(done), 32'(e.dn));
      chk("pulse_count", 32'(pulse_count), 32'(e.cnt));
    end
  endtask

  // Start a burst in the current cycle and check it through completion plus tail cycles.
  // rk: cycle in which start is re-pulsed with different settings while busy (0 = none).
  task automatic run_burst(input int p, input int b, input int ak, input int rk, input int tail);
    int   kl;
    int   n;
    exp_t e;
    kl = (b != 0) ? 1 + (b - 1) * (p + 1) : 0;
    if (ak != 0)     n = ak + 1 + tail;
    else if (b != 0) n = kl + 1 + tail;
    else             n = tail;
    start     = 1'b1;
    abort     = 1'b0;
    period    = 8'(p);
    burst_len = 8'(b);
    e = exp_at(1, p, b, ak);
    push_exp(e);
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      @(negedge clock);
      compare_cycle();
      start     = 1'b0;
      abort     = 1'b0;
      period    = 8'($urandom);
      burst_len = 8'($urandom);
      if (k < n) begin
        if (k == rk) begin
          start     = 1'b1;
          period    = 8'd5;
          burst_len = 8'd7;
        end
        abort = (k == ak);
        e = exp_at(k + 1, p, b, ak);
        push_exp(e);
      end
    end
    if (!e.en) chk("cnt2", 32'(cnt2), 32'(exp_total % 4));
  endtask

  // Idle cycles; st/ab apply to the first cycle only, rst holds for all n.
  task automatic idle_cycles(input int n, input logic st, input logic ab, input logic rst);
    start     = st;
    abort     = ab;
    reset     = rst;
    period    = 8'($urandom);
    burst_len = 8'($urandom_range(255, 1));
    if (rst) begin
      last_cnt  = 0;
      exp_total = 0;
    end
    push_exp(idle_exp(last_cnt));
    for (int i = 1; i <= n; i++) begin
      @(posedge clock);
      @(negedge clock);
      compare_cycle();
      start = 1'b0;
      abort = 1'b0;
      if (i < n) push_exp(idle_exp(last_cnt));
      else reset = 1'b0;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    last_cnt  = 0;
    exp_total = 0;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    period    = 8'd0;
    burst_len = 8'd0;

    // Power-on reset
    idle_cycles(3, 1'b0, 1'b0, 1'b1);

    // Reset held two cycles in the middle of a continuous burst
    run_burst(2, 0, 0, 0, 5);
    idle_cycles(2, 1'b0, 1'b0, 1'b1);
    idle_cycles(2, 1'b0, 1'b0, 1'b0);

    // period=1, four pulses; downstream counter wraps to 0
    run_burst(1, 4, 0, 0, 2);

    // period=0, contiguous three pulses
    run_burst(0, 3, 0, 0, 2);

    // Continuous period=2 aborted during cycle 10
    run_burst(2, 0, 10, 0, 3);

    // start re-pulsed while busy is ignored; start+abort while idle does nothing
    run_burst(1, 3, 0, 2, 2);
    idle_cycles(3, 1'b1, 1'b1, 1'b0);

    // Single-pulse bursts chained by starting in the done cycle
    run_burst(0, 1, 0, 0, 0);
    run_burst(0, 1, 0, 0, 0);
    run_burst(3, 2, 0, 0, 2);

    // Saturating pulse count in continuous mode
    run_burst(0, 0, 258, 0, 2);

    // Widest spacing: full-width prescaler compare
    run_burst(255, 2, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
